ace_rle_loader: RTL and testbench

- Streams a compressed .ACE snapshot from the HPS ioctl interface into Jupiter RAM, starting at a fixed base address.
- Decodes the ED-escape run-length format.
- Holds the CPU off the shared RAM write port while it loads, and pulses a CPU reset when a load starts.
- Replaces ad-hoc loader logic in the top level; sits between hps_io and the ace core's RAM write port.

---
 rtl/ace_rle_loader.sv | 184 ++++++++++++++++++
 tb/tb_ace_rle_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_rle_loader.sv
// ACE snapshot loader: decodes the ED-escape RLE stream from ioctl
// and writes it into Jupiter RAM while holding the CPU off the port.
module ace_rle_loader #(
  parameter logic [15:0] BASE_ADDR      = 16'h2000,
  parameter int unsigned TIMEOUT_CYCLES = 3000000,
  parameter logic [7:0]  ESC_BYTE       = 8'hED
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic        cpu_hold,
  output logic        cpu_reset,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_LIT, S_ESC, S_CNT, S_FILL, S_DELAY, S_STOP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        wr_q, wr_d;
  logic        hold_q, hold_d;
  logic        rst_q, rst_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic        skv_q, skv_d;
  logic [7:0]  skd_q, skd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] tmr_q, tmr_d;
  logic        dl_q, dl_d;
  logic        end_q, end_d;
  logic        wait_q, wait_d;

  logic       start, fall, pend, rdy, fin;
  logic [7:0] din;

  assign start = ioctl_download & ~dl_q & (|ioctl_index);
  assign fall  = ~ioctl_download & dl_q;
  assign pend  = wr_q & ~mem_ack;
  assign rdy   = (state_q inside {S_LIT, S_ESC, S_CNT}) & ~pend;
  assign fin   = end_q & ~wr_q & ~skv_q & (state_q != S_FILL);
  assign din   = skv_q ? skd_q : ioctl_dout;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    hold_d  = hold_q;
    rst_d   = 1'b0;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    skv_d   = skv_q;
    skd_d   = skd_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    dl_d    = ioctl_download;
    end_d   = end_q;
    if (start) begin
      state_d = S_LIT;
      addr_d  = BASE_ADDR;
      rst_d   = 1'b1;
      hold_d  = 1'b1;
      ovr_d   = 1'b0;
      skv_d   = 1'b0;
      wr_d    = 1'b0;
      end_d   = 1'b0;
    end else if (state_q != S_IDLE) begin
      if (fall) end_d = 1'b1;
      if (wr_q && mem_ack) begin
        addr_d = addr_q + 16'd1;
        wr_d   = 1'b0;
        if (state_q == S_FILL) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = S_LIT;
          else wr_d = 1'b1;
        end
      end
      if (state_q == S_DELAY) begin
        if (tmr_q <= 32'd1) state_d = S_STOP;
        else tmr_d = tmr_q - 32'd1;
      end
      if (fin) begin
        state_d = S_IDLE;
        hold_d  = 1'b0;
        done_d  = 1'b1;
        end_d   = 1'b0;
      end else if (rdy && (skv_q || ioctl_wr)) begin
        // a byte arriving while the skid drains takes its place
        if (skv_q) begin
          skv_d = ioctl_wr;
          skd_d = ioctl_dout;
        end
        unique case (1'b1)
          state_q == S_LIT: begin
            if (din == ESC_BYTE) state_d = S_ESC;
            else begin
              data_d = din;
              wr_d   = 1'b1;
            end
          end
          state_q == S_ESC: begin
            cnt_d = din;
            if (din == 8'd0) begin
              state_d = S_DELAY;
              tmr_d   = 32'(TIMEOUT_CYCLES);
              skv_d   = 1'b0;
            end else state_d = S_CNT;
          end
          state_q == S_CNT: begin
            data_d  = din;
            wr_d    = 1'b1;
            state_d = S_FILL;
          end
          default: ;
        endcase
      end else if (ioctl_wr &&
                   (state_q inside {S_LIT, S_ESC, S_CNT, S_FILL})) begin
        if (!skv_q) begin
          skv_d = 1'b1;
          skd_d = ioctl_dout;
        end else ovr_d = 1'b1;
      end
    end
    wait_d = skv_d | wr_d | (state_d == S_FILL) | (state_d == S_DELAY);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      data_q  <= 8'd0;
      wr_q    <= 1'b0;
      hold_q  <= 1'b0;
      rst_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      skv_q   <= 1'b0;
      skd_q   <= 8'd0;
      cnt_q   <= 8'd0;
      tmr_q   <= 32'd0;
      dl_q    <= 1'b0;
      end_q   <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      hold_q  <= hold_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      skv_q   <= skv_d;
      skd_q   <= skd_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      dl_q    <= dl_d;
      end_q   <= end_d;
      wait_q  <= wait_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;
  assign mem_wr     = wr_q;
  assign cpu_hold   = hold_q;
  assign cpu_reset  = rst_q;
  assign done       = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_ace_rle_loader.sv
// Directed bench for ace_rle_loader: literal, run, end marker,
// back-pressure, address wrap, reset abort and restart.
module tb_ace_rle_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dl;
  logic [7:0]  idx;
  logic        wr;
  logic [7:0]  dout;
  logic        ack;

  logic        a_wait, a_mwr, a_hold, a_rst, a_done, a_ovr;
  logic [15:0] a_addr;
  logic [7:0]  a_data;
  logic        b_wait, b_mwr, b_hold, b_rst, b_done, b_ovr;
  logic [15:0] b_addr;
  logic [7:0]  b_data;

  always #5 clk = ~clk;

  ace_rle_loader #(
    .BASE_ADDR(16'h2000), .TIMEOUT_CYCLES(10), .ESC_BYTE(8'hED)
  ) dut_a (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl),
    .ioctl_index(idx), .ioctl_wr(wr), .ioctl_dout(dout),
    .ioctl_wait(a_wait), .mem_addr(a_addr), .mem_data(a_data),
    .mem_wr(a_mwr), .mem_ack(ack), .cpu_hold(a_hold),
    .cpu_reset(a_rst), .done(a_done), .overrun(a_ovr)
  );

  ace_rle_loader #(
    .BASE_ADDR(16'hFFF0), .TIMEOUT_CYCLES(10), .ESC_BYTE(8'hED)
  ) dut_b (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl),
    .ioctl_index(idx), .ioctl_wr(wr), .ioctl_dout(dout),
    .ioctl_wait(b_wait), .mem_addr(b_addr), .mem_data(b_data),
    .mem_wr(b_mwr), .mem_ack(ack), .cpu_hold(b_hold),
    .cpu_reset(b_rst), .done(b_done), .overrun(b_ovr)
  );

  int nchk = 0;
  int nerr = 0;
  logic [23:0] wa[$];
  logic [23:0] wb[$];
  int rst_cnt = 0;

  always @(posedge clk) begin
    if (a_mwr && ack) wa.push_back({a_addr, a_data});
    if (b_mwr && ack) wb.push_back({b_addr, b_data});
    if (a_rst) rst_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    wr = 1'b1;
    dout = b;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic begin_load();
    dl = 1'b1;
    idx = 8'd1;
    @(negedge clk);
  endtask

  task automatic end_load(output bit seen);
    dl = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int w0, wb0, r0, n, bad;
    bit seen;
    reset_n = 1'b0;
    dl = 1'b0; idx = 8'd0; wr = 1'b0; dout = 8'd0; ack = 1'b1;
    tick(2);
    chk("rst_addr", 32'(a_addr), 32'h2000);
    chk("rst_mwr", 32'(a_mwr), 0);
    chk("rst_wait", 32'(a_wait), 0);
    chk("rst_hold", 32'(a_hold), 0);
    chk("rst_cpurst", 32'(a_rst), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_ovr", 32'(a_ovr), 0);
    chk("rst_b_addr", 32'(b_addr), 32'hFFF0);
    chk("rst_b_outs",
        32'({b_wait, b_mwr, b_hold, b_rst, b_done, b_ovr}), 0);
    reset_n = 1'b1;
    tick(2);

    // index 0 download is ignored
    w0 = wa.size(); r0 = rst_cnt;
    dl = 1'b1; idx = 8'd0;
    tick(1);
    send(8'h01);
    tick(2);
    chk("idx0_hold", 32'(a_hold), 0);
    chk("idx0_writes", 32'(wa.size() - w0), 0);
    chk("idx0_cpurst", 32'(rst_cnt - r0), 0);
    dl = 1'b0;
    tick(2);

    // literal stream
    w0 = wa.size(); r0 = rst_cnt;
    begin_load();
    chk("lit_cpurst", 32'(a_rst), 1);
    chk("lit_hold", 32'(a_hold), 1);
    send(8'h01); send(8'h02); send(8'h03);
    tick(2);
    chk("lit_count", 32'(wa.size() - w0), 3);
    chk("lit_w0", 32'(wa[w0]), 32'h200001);
    chk("lit_w1", 32'(wa[w0 + 1]), 32'h200102);
    chk("lit_w2", 32'(wa[w0 + 2]), 32'h200203);
    chk("lit_rstpulses", 32'(rst_cnt - r0), 1);
    end_load(seen);
    chk("lit_done", 32'(seen), 1);
    chk("lit_hold_off", 32'(a_hold), 0);

    // run then literal
    begin_load();
    w0 = wa.size();
    send(8'hED); send(8'h04); send(8'hAA);
    chk("run_wait", 32'(a_wait), 1);
    tick(6);
    send(8'h55);
    tick(2);
    chk("run_count", 32'(wa.size() - w0), 5);
    for (int i = 0; i < 4; i++)
      chk("run_fill", 32'(wa[w0 + i]), {8'h00, 16'h2000 + 16'(i), 8'hAA});
    chk("run_lit", 32'(wa[w0 + 4]), 32'h200455);
    end_load(seen);
    chk("run_done", 32'(seen), 1);

    // end marker and timeout
    begin_load();
    w0 = wa.size();
    send(8'hED); send(8'h00);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (!a_wait) break;
      n++;
      wr = (i == 2);
      dout = 8'h77;
      @(negedge clk);
    end
    wr = 1'b0;
    chk("end_wait_cycles", 32'(n), 10);
    send(8'h77);
    tick(2);
    chk("end_no_write", 32'(wa.size() - w0), 0);
    chk("end_ovr", 32'(a_ovr), 0);
    end_load(seen);
    chk("end_done", 32'(seen), 1);

    // back-pressure, skid and overrun
    ack = 1'b0;
    begin_load();
    w0 = wa.size();
    wr = 1'b1; dout = 8'h31;
    @(negedge clk);
    dout = 8'h32;
    @(negedge clk);
    wr = 1'b0;
    tick(4);
    send(8'h33);
    chk("bp_ovr", 32'(a_ovr), 1);
    chk("bp_mwr", 32'(a_mwr), 1);
    chk("bp_data", 32'(a_data), 32'h31);
    chk("bp_addr", 32'(a_addr), 32'h2000);
    chk("bp_wait", 32'(a_wait), 1);
    tick(12);
    chk("bp_stalled", 32'(wa.size() - w0), 0);
    ack = 1'b1;
    tick(4);
    chk("bp_count", 32'(wa.size() - w0), 2);
    chk("bp_w0", 32'(wa[w0]), 32'h200031);
    chk("bp_w1", 32'(wa[w0 + 1]), 32'h200132);
    end_load(seen);
    chk("bp_done", 32'(seen), 1);
    chk("bp_ovr_sticky", 32'(a_ovr), 1);

    // 255-byte run, B wraps its address
    begin_load();
    chk("wrap_ovr_clr", 32'(a_ovr), 0);
    w0 = wa.size(); wb0 = wb.size();
    send(8'hED); send(8'hFF); send(8'h11);
    chk("wrap_wait", 32'(a_wait), 1);
    chk("wrap_hold", 32'(a_hold), 1);
    end_load(seen);
    chk("wrap_done", 32'(seen), 1);
    chk("wrap_a_count", 32'(wa.size() - w0), 255);
    chk("wrap_b_count", 32'(wb.size() - wb0), 255);
    chk("wrap_a_last", 32'(wa[w0 + 254]), 32'h20FE11);
    chk("wrap_b_first", 32'(wb[wb0]), 32'hFFF011);
    chk("wrap_b_ffff", 32'(wb[wb0 + 15]), 32'hFFFF11);
    chk("wrap_b_0000", 32'(wb[wb0 + 16]), 32'h000011);
    chk("wrap_b_last", 32'(wb[wb0 + 254]), 32'h00EE11);
    bad = 0;
    for (int i = 0; i < 255; i++)
      if (wb[wb0 + i] !== {16'hFFF0 + 16'(i), 8'h11}) bad++;
    chk("wrap_b_all", 32'(bad), 0);

    // async reset mid-fill
    begin_load();
    send(8'hED); send(8'h10); send(8'h22);
    tick(3);
    reset_n = 1'b0;
    dl = 1'b0;
    #1;
    chk("abort_mwr", 32'(a_mwr), 0);
    chk("abort_hold", 32'(a_hold), 0);
    chk("abort_wait", 32'(a_wait), 0);
    chk("abort_addr", 32'(a_addr), 32'h2000);
    w0 = wa.size();
    @(negedge clk);
    tick(3);
    reset_n = 1'b1;
    tick(4);
    chk("abort_no_write", 32'(wa.size() - w0), 0);
    chk("abort_mwr_idle", 32'(a_mwr), 0);

    // restart during a fill
    begin_load();
    send(8'hED); send(8'h08); send(8'h33);
    tick(2);
    chk("restart_infill", 32'(a_mwr), 1);
    r0 = rst_cnt;
    dl = 1'b0;
    @(negedge clk);
    dl = 1'b1;
    @(negedge clk);
    chk("restart_cpurst", 32'(a_rst), 1);
    chk("restart_addr", 32'(a_addr), 32'h2000);
    chk("restart_mwr", 32'(a_mwr), 0);
    w0 = wa.size();
    send(8'h44);
    tick(2);
    chk("restart_count", 32'(wa.size() - w0), 1);
    chk("restart_w0", 32'(wa[w0]), 32'h200044);
    chk("restart_pulses", 32'(rst_cnt - r0), 1);
    end_load(seen);
    chk("restart_done", 32'(seen), 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
